// File: rtl/alu_bist_seq.sv
// ---------------------------------------------------------------------------
// alu_bist_seq -- self-test sequencer for the ALU datapath.
//
// Reads NUM_VEC frames {a, b, c_in, op, exp} from a vector memory. For each
// frame it drives the ALU, waits ALU_LAT cycles and compares alu_y against
// exp. Pass and fail counts saturate at all-ones. The address of the first
// mismatch in a run is captured. Supports a start/busy/done handshake, loop
// mode and abort.
//
// Optional feature: define BIST_STOP_ON_FAIL_EN to end the run on the first
// mismatch. When it is defined, CMP goes to DONE after the counters and
// fail_* have been updated.
//
// Ports:
//   clk, reset          rising-edge clock; asynchronous active-high reset
//   start               begin a run (sampled in IDLE or DONE)
//   abort               synchronous abort back to IDLE; counters are held
//   loop_mode           wrap to vector 0 after the last vector
//   mem_addr, mem_en    vector memory address / one-cycle read strobe
//   mem_data            frame, valid one cycle after mem_en
//   alu_a, alu_b        ALU operands
//   alu_cin, alu_op     ALU carry-in and opcode
//   alu_en              one-cycle ALU enable
//   alu_y               ALU result
//   busy, done          run in progress / run complete
//   pass_cnt, fail_cnt  saturating match / mismatch counters
//   fail_valid          at least one mismatch in this run
//   fail_addr           address of the first mismatch
//   result              {pass_cnt[7:0], fail_cnt[7:0]}
// ---------------------------------------------------------------------------
module alu_bist_seq #(
  parameter int unsigned DATA_W  = 4,
  parameter int unsigned OP_W    = 4,
  parameter int unsigned NUM_VEC = 8,
  parameter int unsigned ADDR_W  = 3,
  parameter int unsigned ALU_LAT = 1,
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned FRAME_W = 3*DATA_W + OP_W + 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic               loop_mode,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic               mem_en,
  input  logic [FRAME_W-1:0] mem_data,
  output logic [DATA_W-1:0]  alu_a,
  output logic [DATA_W-1:0]  alu_b,
  output logic               alu_cin,
  output logic [OP_W-1:0]    alu_op,
  output logic               alu_en,
  input  logic [DATA_W-1:0]  alu_y,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   pass_cnt,
  output logic [CNT_W-1:0]   fail_cnt,
  output logic               fail_valid,
  output logic [ADDR_W-1:0]  fail_addr,
  output logic [15:0]        result
);

  // Frame field positions, LSB first: exp, op, c_in, b, a.
  localparam int unsigned EXP_LSB = 0;
  localparam int unsigned OP_LSB  = DATA_W;
  localparam int unsigned CIN_BIT = DATA_W + OP_W;
  localparam int unsigned B_LSB   = DATA_W + OP_W + 1;
  localparam int unsigned A_LSB   = 2*DATA_W + OP_W + 1;

  // Wait counter only needs to span 0..ALU_LAT-1.
  localparam int unsigned LAT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_VEC - 1);
  localparam logic [LAT_W-1:0]  LAST_WAIT = LAT_W'(ALU_LAT - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LATCH,
    S_EXEC,
    S_WAIT,
    S_CMP,
    S_DONE
  } state_t;

  state_t            state;
  logic [LAT_W-1:0]  wait_cnt;
  logic [DATA_W-1:0] exp_q;
  logic              match_c;
  logic              stop_on_fail_c;

  // Full-width unsigned compare of the ALU result against the latched expectation.
  assign match_c = (alu_y == exp_q);

`ifdef BIST_STOP_ON_FAIL_EN
  assign stop_on_fail_c = 1'b1;
`else
  assign stop_on_fail_c = 1'b0;
`endif

  // result always reflects the low byte of each counter.
  assign result = {pass_cnt[7:0], fail_cnt[7:0]};

  // Sequencer FSM. All handshake, strobe and datapath outputs are registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      wait_cnt   <= '0;
      exp_q      <= '0;
      mem_addr   <= '0;
      mem_en     <= 1'b0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_cin    <= 1'b0;
      alu_op     <= '0;
      alu_en     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass_cnt   <= '0;
      fail_cnt   <= '0;
      fail_valid <= 1'b0;
      fail_addr  <= '0;
    end else begin
      // The strobes are single-cycle pulses unless a transition re-asserts them.
      mem_en <= 1'b0;
      alu_en <= 1'b0;

      if (abort) begin
        // Abort takes priority over start. Counters and fail_* are left untouched.
        state <= S_IDLE;
        busy  <= 1'b0;
        done  <= 1'b0;
      end else begin
        case (state)
          S_IDLE, S_DONE: begin
            if (start) begin
              state      <= S_FETCH;
              mem_addr   <= '0;
              mem_en     <= 1'b1;
              pass_cnt   <= '0;
              fail_cnt   <= '0;
              fail_valid <= 1'b0;
              fail_addr  <= '0;
              busy       <= 1'b1;
              done       <= 1'b0;
            end
          end

          S_FETCH: begin
            state <= S_LATCH;
          end

          // The frame arrives this cycle. The operands stay held until the next LATCH.
          S_LATCH: begin
            alu_a   <= mem_data[A_LSB +: DATA_W];
            alu_b   <= mem_data[B_LSB +: DATA_W];
            alu_cin <= mem_data[CIN_BIT];
            alu_op  <= mem_data[OP_LSB +: OP_W];
            exp_q   <= mem_data[EXP_LSB +: DATA_W];
            alu_en  <= 1'b1;
            state   <= S_EXEC;
          end

          S_EXEC: begin
            wait_cnt <= '0;
            state    <= S_WAIT;
          end

          S_WAIT: begin
            if (wait_cnt == LAST_WAIT) begin
              state <= S_CMP;
            end else begin
              wait_cnt <= wait_cnt + LAT_W'(1);
            end
          end

          S_CMP: begin
            if (match_c) begin
              if (pass_cnt != CNT_MAX) begin
                pass_cnt <= pass_cnt + CNT_W'(1);
              end
            end else begin
              if (fail_cnt != CNT_MAX) begin
                fail_cnt <= fail_cnt + CNT_W'(1);
              end
              if (!fail_valid) begin
                fail_valid <= 1'b1;
                fail_addr  <= mem_addr;
              end
            end

            // loop_mode is consulted only here, on the last vector.
            if (stop_on_fail_c && !match_c) begin
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else if (mem_addr != LAST_ADDR) begin
              mem_addr <= mem_addr + ADDR_W'(1);
              mem_en   <= 1'b1;
              state    <= S_FETCH;
            end else if (loop_mode) begin
              mem_addr <= '0;
              mem_en   <= 1'b1;
              state    <= S_FETCH;
            end else begin
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end

          default: begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
